// File: rtl/cache_mem_write_buffer.sv
// Posted-write buffer between a cache and main memory: writebacks queue in a FIFO
// that drains in order, read misses go to memory, reads hitting a queued line are served locally.
module cache_mem_write_buffer #(
    parameter int ADDR_W = 10,
    parameter int LINE_W = 128,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LINE_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [LINE_W-1:0] rsp_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [LINE_W-1:0] mem_rdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT} stateT;

    stateT             state, nextState;
    logic [ADDR_W-1:0] addrQ [DEPTH];
    logic [LINE_W-1:0] dataQ [DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count;
    logic              outOfReset, reqReady;
    logic              reqAccept, pushEn, popEn, memFire, readHit, readMiss;
    logic              hit;
    logic [LINE_W-1:0] hitData;
    logic [ADDR_W-1:0] rdAddr;
    logic              memValid, memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [LINE_W-1:0] memWdata;
    logic              rspValid;
    logic [LINE_W-1:0] rspData;

    assign reqAccept = req_valid && reqReady;
    assign pushEn    = reqAccept && req_we;
    assign readHit   = reqAccept && !req_we && hit;
    assign readMiss  = reqAccept && !req_we && !hit;
    assign memFire   = memValid && mem_req_ready;
    assign popEn     = memFire && memWe;

    // Scan oldest to newest so the most recent matching writeback wins.
    always_comb begin
        hit     = 1'b0;
        hitData = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count) && (addrQ[head + PTR_W'(i)] == req_addr)) begin
                hit     = 1'b1;
                hitData = dataQ[head + PTR_W'(i)];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:     if (readMiss) nextState = RD_ISSUE;
            RD_ISSUE: if (memFire && !memWe) nextState = RD_WAIT;
            RD_WAIT:  if (mem_rsp_valid) nextState = IDLE;
            default:  nextState = IDLE;
        endcase
    end

    // outOfReset keeps req_ready low while reset is applied and until the first clock after release.
    always_comb begin
        reqReady = outOfReset && (state == IDLE) && (count < CNT_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (pushEn) begin
            addrQ[tail] <= req_addr;
            dataQ[tail] <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outOfReset <= 1'b0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            rdAddr     <= '0;
            memValid   <= 1'b0;
            memWe      <= 1'b0;
            memAddr    <= '0;
            memWdata   <= '0;
            rspValid   <= 1'b0;
            rspData    <= '0;
        end else begin
            outOfReset <= 1'b1;
            rspValid   <= readHit || ((state == RD_WAIT) && mem_rsp_valid);
            if (readHit)                              rspData <= hitData;
            else if ((state == RD_WAIT) && mem_rsp_valid) rspData <= mem_rdata;
            if (readMiss) rdAddr <= req_addr;
            if (pushEn)   tail   <= tail + 1'b1;
            if (popEn)    head   <= head + 1'b1;
            case ({pushEn, popEn})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A presented request is held unchanged until memory takes it; a write
            // already in flight when a miss arrives finishes before the read is loaded.
            if (memFire) begin
                memValid <= 1'b0;
                memWe    <= 1'b0;
            end else if (!memValid) begin
                if ((state == IDLE) && (count != '0) && !readMiss) begin
                    memValid <= 1'b1;
                    memWe    <= 1'b1;
                    memAddr  <= addrQ[head];
                    memWdata <= dataQ[head];
                end else if (state == RD_ISSUE) begin
                    memValid <= 1'b1;
                    memWe    <= 1'b0;
                    memAddr  <= rdAddr;
                    memWdata <= '0;
                end
            end
        end
    end

    assign req_ready     = reqReady;
    assign rsp_valid     = rspValid;
    assign rsp_rdata     = rspData;
    assign mem_req_valid = memValid;
    assign mem_we        = memWe;
    assign mem_addr      = memAddr;
    assign mem_wdata     = memWdata;

endmodule
